// File: rtl/seq_shift_add_mult.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_shift_add_mult / claAdder : 16x16->32 unsigned shift-and-add multiplier
// Revision: 1.0
// ---------------------------------------------------------------------------

module claAdder (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [3:0] grp_g;
  logic [3:0] grp_p;
  logic [3:0] grp_c;

  // Group carries are fully expanded so no carry ripples between nibbles.
  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign cout     = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_grp
      logic [3:0] gi;
      logic [3:0] pi;
      logic [3:0] cc;

      assign gi = in1[4*k +: 4] & in2[4*k +: 4];
      assign pi = in1[4*k +: 4] ^ in2[4*k +: 4];

      assign cc[0] = grp_c[k];
      assign cc[1] = gi[0] | (pi[0] & grp_c[k]);
      assign cc[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & grp_c[k]);
      assign cc[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                   | (pi[2] & pi[1] & pi[0] & grp_c[k]);

      assign grp_g[k] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
                      | (pi[3] & pi[2] & pi[1] & gi[0]);
      assign grp_p[k] = &pi;

      assign sum[4*k +: 4] = pi ^ cc;
    end
  endgenerate
endmodule

module seq_shift_add_mult #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_in2;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  assign add_in2 = mq_q[0] ? m_q : '0;

  claAdder u_adder (
    .in1  (acc_q),
    .in2  (add_in2),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The adder carry is shifted straight into the accumulator MSB each cycle,
  // so the carry bit of {C,A,Q} never needs its own storage.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          m_d     = a;
          mq_d    = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = {add_cout, add_sum[WIDTH-1:1]};
        mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC);
  assign product   = {acc_q, mq_q};
endmodule
`default_nettype wire
